lane_sprite_plotter: RTL and testbench

- Sits directly downstream of CharacterFSM and directly upstream of the VGA adapter.
- On each move reported by the FSM, it erases the sprite box at the previous lane position, then draws it at the current lane position.
- Output is one pixel per clock as XOut/YOut/Color/Plot, followed by a single-cycle DoneDrawing pulse back to the FSM.
- Provides the erase-then-draw sequencing the game loop needs without a frame buffer.

---
 rtl/lane_sprite_plotter.sv | 168 ++++++++++++++++
 tb/tb_lane_sprite_plotter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lane_sprite_plotter.sv
// lane_sprite_plotter
//
// Erase-then-draw pixel sequencer that sits between CharacterFSM and the
// VGA adapter. Each accepted move first paints the sprite box at the old
// lane with the background colour. It then paints the box at the new lane
// with the foreground colour, one pixel per clock, and finishes with a
// single-cycle DoneDrawing pulse. After reset the box at CurrState is drawn
// once without waiting for Start, so the sprite is visible from power-up.
//
// Ports:
//   CLOCK_50     in   1  system clock, rising edge
//   Reset        in   1  asynchronous reset, active low
//   Start        in   1  one-cycle move request (honoured only in IDLE)
//   CurrState    in   4  new lane index (clamped to NUM_POS-1)
//   PrevState    in   4  old lane index (clamped to NUM_POS-1)
//   XOut         out  8  pixel X
//   YOut         out  7  pixel Y
//   Color        out  3  pixel colour
//   Plot         out  1  pixel write strobe
//   Busy         out  1  high from the first Plot cycle through DoneDrawing
//   DoneDrawing  out  1  one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for the power-up draw or for a Start request
// ERASE | scanning the box at prev_pos with BG_COLOR
// DRAW  | scanning the box at cur_pos with FG_COLOR
// DONE  | one-cycle DoneDrawing pulse, then back to IDLE

module lane_sprite_plotter #(
    parameter int         NUM_POS  = 4,
    parameter int         SPRITE_W = 8,
    parameter int         SPRITE_H = 8,
    parameter int         X_ORIGIN = 20,
    parameter int         X_PITCH  = 32,
    parameter int         Y_ROW    = 100,
    parameter logic [2:0] FG_COLOR = 3'b111,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] CurrState,
    input  logic [3:0] PrevState,
    output logic [7:0] XOut,
    output logic [6:0] YOut,
    output logic [2:0] Color,
    output logic       Plot,
    output logic       Busy,
    output logic       DoneDrawing
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    logic       init_pending;
    logic [3:0] cur_pos;
    logic [3:0] prev_pos;
    logic [7:0] col;
    logic [6:0] row;

    logic [3:0] curr_clamped;
    logic [3:0] prev_clamped;
    logic [3:0] scan_pos;
    logic [8:0] x_sum;
    logic [6:0] y_sum;
    logic       col_last;
    logic       row_last;
    logic       x_unused;

    // Out-of-range lane indices snap to the rightmost lane.
    function automatic logic [3:0] clamp_pos(input logic [3:0] p);
        if (int'(p) >= NUM_POS) begin
            return 4'(NUM_POS - 1);
        end
        return p;
    endfunction

    always_comb begin
        curr_clamped = clamp_pos(CurrState);
        prev_clamped = clamp_pos(PrevState);
        scan_pos     = (state == ERASE) ? prev_pos : cur_pos;
        // Sum carried at 9 bits; only the low 8 reach the screen.
        x_sum        = 9'(X_ORIGIN + int'(scan_pos) * X_PITCH + int'(col));
        y_sum        = 7'(Y_ROW + int'(row));
        col_last     = (col == 8'(SPRITE_W - 1));
        row_last     = (row == 7'(SPRITE_H - 1));
    end

    // Parameter limits keep the box on screen, so the carry bit is dropped.
    assign x_unused = x_sum[8];

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            init_pending <= 1'b1;
            cur_pos      <= '0;
            prev_pos     <= '0;
            col          <= '0;
            row          <= '0;
            XOut         <= '0;
            YOut         <= '0;
            Color        <= '0;
            Plot         <= 1'b0;
            Busy         <= 1'b0;
            DoneDrawing  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Plot        <= 1'b0;
                    Color       <= '0;
                    Busy        <= 1'b0;
                    DoneDrawing <= 1'b0;
                    col         <= '0;
                    row         <= '0;
                    if (init_pending) begin
                        // Power-up draw: nothing on screen yet, so no erase;
                        // a concurrent Start is not honoured.
                        cur_pos      <= curr_clamped;
                        init_pending <= 1'b0;
                        state        <= DRAW;
                    end else if (Start) begin
                        cur_pos  <= curr_clamped;
                        prev_pos <= prev_clamped;
                        state    <= (curr_clamped == prev_clamped) ? DRAW : ERASE;
                    end
                end

                ERASE, DRAW: begin
                    Plot        <= 1'b1;
                    Busy        <= 1'b1;
                    DoneDrawing <= 1'b0;
                    Color       <= (state == ERASE) ? BG_COLOR : FG_COLOR;
                    XOut        <= x_sum[7:0];
                    YOut        <= y_sum;
                    if (col_last) begin
                        col <= '0;
                        if (row_last) begin
                            row   <= '0;
                            state <= (state == ERASE) ? DRAW : DONE;
                        end else begin
                            row <= row + 7'd1;
                        end
                    end else begin
                        col <= col + 8'd1;
                    end
                end

                DONE: begin
                    Plot        <= 1'b0;
                    Color       <= '0;
                    Busy        <= 1'b1;
                    DoneDrawing <= 1'b1;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_sprite_plotter.sv
module tb_lane_sprite_plotter;

    logic       clk;
    logic       Reset;
    logic       Start;
    logic [3:0] CurrState;
    logic [3:0] PrevState;
    logic [7:0] XOut;
    logic [6:0] YOut;
    logic [2:0] Color;
    logic       Plot;
    logic       Busy;
    logic       DoneDrawing;

    lane_sprite_plotter dut (
        .CLOCK_50    (clk),
        .Reset       (Reset),
        .Start       (Start),
        .CurrState   (CurrState),
        .PrevState   (PrevState),
        .XOut        (XOut),
        .YOut        (YOut),
        .Color       (Color),
        .Plot        (Plot),
        .Busy        (Busy),
        .DoneDrawing (DoneDrawing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic [3:0] prev;
        logic [3:0] curr;
        bit         erase;
        int         elane;
        int         dlane;
        int         lat;
    } vec_t;

    pix_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   done_count = 0;
    int   done_cycle = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Expected pixels of one box, row-major, from the bench's own geometry.
    task automatic push_box(input int lane, input logic [2:0] color);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                pix_t p;
                p.x = 8'(20 + lane * 32 + c);
                p.y = 7'(100 + r);
                p.c = color;
                exp_q.push_back(p);
            end
        end
    endtask

    // Output monitor: every Plot pops one expected pixel.
    always @(negedge clk) begin
        if (Reset) begin
            if (Plot) begin
                if (exp_q.size() == 0) begin
                    chk("plot_unexpected", int'(Plot), 0);
                end else begin
                    pix_t p;
                    p = exp_q.pop_front();
                    chk("pixel_x", int'(XOut), int'(p.x));
                    chk("pixel_y", int'(YOut), int'(p.y));
                    chk("pixel_color", int'(Color), int'(p.c));
                    chk("busy_while_plot", int'(Busy), 1);
                end
            end
            if (DoneDrawing) begin
                done_count++;
                done_cycle = cyc;
                chk("done_plot", int'(Plot), 0);
                chk("done_busy", int'(Busy), 1);
                chk("done_color", int'(Color), 0);
            end
        end
    end

    // Called just after a negedge; Start is sampled at the next posedge.
    task automatic start_move(input vec_t v, output int n);
        PrevState = v.prev;
        CurrState = v.curr;
        Start     = 1'b1;
        if (v.erase) push_box(v.elane, 3'b000);
        push_box(v.dlane, 3'b111);
        n = cyc + 1;
        @(negedge clk); #1;
        Start = 1'b0;
    endtask

    // Waits for DoneDrawing; optional Start pulses land in ERASE and DRAW.
    task automatic wait_done(input int n, input int lat, input bit pulses);
        int d0;
        bit got;
        d0  = done_count;
        got = 1'b0;
        for (int i = 1; i <= 300 && !got; i++) begin
            @(negedge clk); #1;
            if (pulses) begin
                Start     = (i == 20 || i == 100);
                CurrState = 4'(i % 4);
                PrevState = 4'((i + 1) % 4);
            end
            if (done_count != d0) got = 1'b1;
        end
        Start = 1'b0;
        chk("done_seen", int'(got), 1);
        if (got) chk("done_latency", done_cycle - n, lat);
        chk("queue_empty_at_done", exp_q.size(), 0);
    endtask

    task automatic check_after_done();
        @(negedge clk); #1;
        chk("busy_after_done", int'(Busy), 0);
        chk("done_one_cycle", int'(DoneDrawing), 0);
    endtask

    vec_t vecs[5];
    vec_t va, vb, vr;
    int   n;
    int   d_before;

    initial begin
        //          prev   curr   erase elane dlane lat
        vecs[0] = '{4'd0,  4'd1,  1'b1, 0,    1,    129};
        vecs[1] = '{4'd2,  4'd2,  1'b0, 0,    2,    65};
        vecs[2] = '{4'd0,  4'd9,  1'b1, 0,    3,    129};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 0,    3,    65};
        vecs[4] = '{4'd3,  4'd0,  1'b1, 3,    0,    129};

        Reset     = 1'b0;
        Start     = 1'b0;
        CurrState = 4'd0;
        PrevState = 4'd2;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_xout", int'(XOut), 0);
        chk("rst_yout", int'(YOut), 0);
        chk("rst_color", int'(Color), 0);
        chk("rst_plot", int'(Plot), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(DoneDrawing), 0);

        // Power-up draw at lane 0; a Start pulse during it is ignored.
        push_box(0, 3'b111);
        n = cyc + 1;
        Reset = 1'b1;
        wait_done(n, 65, 1'b1);
        check_after_done();
        repeat (5) @(negedge clk);
        #1;

        foreach (vecs[k]) begin
            start_move(vecs[k], n);
            wait_done(n, vecs[k].lat, 1'b0);
            check_after_done();
            repeat (3) @(negedge clk);
            #1;
        end

        // Start pulses mid-operation are ignored, then a back-to-back move
        // issued in the DoneDrawing cycle is accepted.
        va = '{4'd1, 4'd3, 1'b1, 1, 3, 129};
        vb = '{4'd3, 4'd2, 1'b1, 3, 2, 129};
        d_before = done_count;
        start_move(va, n);
        wait_done(n, 129, 1'b1);
        start_move(vb, n);
        wait_done(n, 129, 1'b0);
        check_after_done();
        repeat (20) @(negedge clk);
        #1;
        chk("done_pulses_total", done_count - d_before, 2);

        // Reset during pixel 30 of a draw.
        vr = '{4'd2, 4'd2, 1'b0, 0, 2, 65};
        start_move(vr, n);
        repeat (31) @(negedge clk);
        #1;
        chk("pixels_before_reset", exp_q.size(), 33);
        Reset = 1'b0;
        #1;
        chk("midrst_plot", int'(Plot), 0);
        chk("midrst_xout", int'(XOut), 0);
        chk("midrst_busy", int'(Busy), 0);
        exp_q.delete();
        CurrState = 4'd1;
        PrevState = 4'd3;
        Start     = 1'b1;
        @(negedge clk); #1;
        push_box(1, 3'b111);
        n = cyc + 1;
        Reset = 1'b1;
        @(negedge clk); #1;
        Start = 1'b0;
        wait_done(n, 65, 1'b0);
        check_after_done();
        repeat (10) @(negedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
